// File: rtl/loop_tstate_sequencer.sv
// Loop-control T-state sequencer: runs N iterations of T_PHASES phases and strobes
// Tstate in the execute (last) phase, with hold, abort and in-flight augment.
module loop_tstate_sequencer #(
  parameter int CNT_W    = 8,
  parameter int T_PHASES = 4,
  parameter int PH_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load_count,
  input  logic             hold,
  input  logic             augment,
  input  logic             abort,
  output logic             Tstate,
  output logic [PH_W-1:0]  phase,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             busy,
  output logic             done,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

  localparam logic [PH_W-1:0]  LAST_PH = PH_W'(T_PHASES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_exec;

  logic [CNT_W-1:0] w_cnt_inc;
  logic [PH_W-1:0]  w_ph_inc;
  logic             w_unused;

  // Supply/substrate pins are physical ties only.
  assign w_unused  = CELV ^ CELG ^ SUB;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
  assign w_ph_inc  = r_phase + PH_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_exec  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_phase <= '0;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_exec  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_exec <= 1'b0;
            if (start) begin
              r_cnt <= load_count;
              if (load_count != '0) begin
                r_state <= S_SETUP;
                r_busy  <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          S_SETUP: begin
            r_state <= S_RUN;
            r_phase <= '0;
            r_exec  <= 1'b0;
          end
          S_RUN: begin
            if (hold) begin
              if (augment) r_cnt <= w_cnt_inc;
            end else if (r_phase == LAST_PH) begin
              r_phase <= '0;
              r_exec  <= 1'b0;
              // Augment on the decrementing edge cancels out and the loop keeps going.
              if (!augment) begin
                r_cnt <= r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end
            end else begin
              r_phase <= w_ph_inc;
              r_exec  <= (w_ph_inc == LAST_PH);
              if (augment) r_cnt <= w_cnt_inc;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_exec  <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Execute decode is registered; hold masks it combinationally so gating cells drop at once.
  assign Tstate   = r_exec & ~hold;
  assign phase    = r_phase;
  assign iter_cnt = r_cnt;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_loop_tstate_sequencer.sv
// Cycle-accurate scenario bench: expected outputs per cycle are queued from the
// timing plan and popped/compared as the sequencer runs.
module tb_loop_tstate_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] load_count = '0;
  logic       hold = 1'b0;
  logic       augment = 1'b0;
  logic       abort = 1'b0;
  logic       Tstate;
  logic [3:0] phase;
  logic [7:0] iter_cnt;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          cyc;
    logic [14:0] v;  // {Tstate, busy, done, phase, iter_cnt}
  } exp_t;
  exp_t sb[$];

  loop_tstate_sequencer #(.CNT_W(8), .T_PHASES(4), .PH_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .load_count(load_count),
    .hold(hold), .augment(augment), .abort(abort),
    .Tstate(Tstate), .phase(phase), .iter_cnt(iter_cnt), .busy(busy), .done(done),
    .CELV(1'b1), .CELG(1'b0), .SUB(1'b0)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] mk(bit ts, bit bz, bit dn, int ph, int cnt);
    return {ts, bz, dn, 4'(ph), 8'(cnt)};
  endfunction

  task automatic push(int c, logic [14:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic set_in(bit st, int ld, bit hd, bit ag, bit ab);
    start      = st;
    load_count = 8'(ld);
    hold       = hd;
    augment    = ag;
    abort      = ab;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n = 0;
    rst = 1'b1;
    set_in(1, 5, 1, 1, 1);
    align();
    for (int c = 0; c < 3; c++) push(c, mk(0, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      exp_t e;
      #1;
      e = sb.pop_front();
      total++; n++;
      if ({Tstate, busy, done, phase, iter_cnt} !== e.v) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h want=%h", e.cyc, {Tstate, busy, done, phase, iter_cnt}, e.v);
      end
      align();
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    align();
    $display("reset: %0d cycles checked", n);
  endtask

  task automatic test_basic();
    int n = 0;
    for (int c = 0; c <= 16; c++) begin
      int cnt = (c == 0) ? 0 : (c <= 5) ? 3 : (c <= 9) ? 2 : (c <= 13) ? 1 : 0;
      int ph  = (c >= 2 && c <= 13) ? (c - 2) % 4 : 0;
      push(c, mk(c == 5 || c == 9 || c == 13, c >= 1 && c <= 13, c == 14, ph, cnt));
    end
    align();
    for (int c = 0; c <= 16; c++) begin
      exp_t e;
      set_in(c == 0, 3, 0, 0, 0);
      #1;
      e = sb.pop_front();
      total++; n++;
      if ({Tstate, busy, done, phase, iter_cnt} !== e.v) begin
        bad++;
        $display("FAIL basic cyc=%0d got=%h want=%h", e.cyc, {Tstate, busy, done, phase, iter_cnt}, e.v);
      end
      align();
    end
    $display("basic load=3: %0d cycles checked", n);
  endtask

  task automatic test_zero_count();
    int n = 0;
    for (int c = 0; c <= 4; c++) push(c, mk(0, 0, c == 1, 0, 0));
    align();
    for (int c = 0; c <= 4; c++) begin
      exp_t e;
      set_in(c <= 1, (c == 1) ? 7 : 0, 0, 0, 0);
      #1;
      e = sb.pop_front();
      total++; n++;
      if ({Tstate, busy, done, phase, iter_cnt} !== e.v) begin
        bad++;
        $display("FAIL zero_count cyc=%0d got=%h want=%h", e.cyc, {Tstate, busy, done, phase, iter_cnt}, e.v);
      end
      align();
    end
    $display("zero count: %0d cycles checked", n);
  endtask

  task automatic test_hold();
    int n = 0;
    int ph_a[15] = '{0, 0, 0, 1, 2, 2, 2, 2, 3, 0, 1, 2, 3, 0, 0};
    int ph_b[9]  = '{0, 0, 0, 1, 2, 3, 3, 0, 0};
    // Hold through phase 2 delays both execute strobes by three cycles.
    for (int c = 0; c <= 14; c++) begin
      int cnt = (c >= 1 && c <= 8) ? 2 : (c >= 9 && c <= 12) ? 1 : 0;
      push(c, mk(c == 8 || c == 12, c >= 1 && c <= 12, c == 13, ph_a[c], cnt));
    end
    // Hold landing on the execute phase masks Tstate and stretches that phase.
    for (int c = 0; c <= 8; c++)
      push(c, mk(c == 6, c >= 1 && c <= 6, c == 7, ph_b[c], (c >= 1 && c <= 6) ? 1 : 0));
    align();
    for (int c = 0; c <= 14; c++) begin
      exp_t e;
      set_in(c == 0, 2, c >= 4 && c <= 6, 0, 0);
      #1;
      e = sb.pop_front();
      total++; n++;
      if ({Tstate, busy, done, phase, iter_cnt} !== e.v) begin
        bad++;
        $display("FAIL hold_mid cyc=%0d got=%h want=%h", e.cyc, {Tstate, busy, done, phase, iter_cnt}, e.v);
      end
      align();
    end
    for (int c = 0; c <= 8; c++) begin
      exp_t e;
      set_in(c == 0, 1, c == 5, 0, 0);
      #1;
      e = sb.pop_front();
      total++; n++;
      if ({Tstate, busy, done, phase, iter_cnt} !== e.v) begin
        bad++;
        $display("FAIL hold_exec cyc=%0d got=%h want=%h", e.cyc, {Tstate, busy, done, phase, iter_cnt}, e.v);
      end
      align();
    end
    $display("hold: %0d cycles checked", n);
  endtask

  task automatic test_augment();
    int n = 0;
    for (int c = 0; c <= 11; c++) begin
      int ph = (c >= 2 && c <= 9) ? (c - 2) % 4 : 0;
      push(c, mk(c == 5 || c == 9, c >= 1 && c <= 9, c == 10, ph, (c >= 1 && c <= 9) ? 1 : 0));
    end
    // 254 -> 255 on the first augment, then saturates; abort clears without done.
    for (int c = 0; c <= 6; c++) begin
      int cnt = (c == 1 || c == 2) ? 254 : (c == 3 || c == 4) ? 255 : 0;
      int ph  = (c >= 2 && c <= 4) ? c - 2 : 0;
      push(c, mk(0, c >= 1 && c <= 4, 0, ph, cnt));
    end
    align();
    for (int c = 0; c <= 11; c++) begin
      exp_t e;
      set_in(c == 0, 1, 0, c == 5, 0);
      #1;
      e = sb.pop_front();
      total++; n++;
      if ({Tstate, busy, done, phase, iter_cnt} !== e.v) begin
        bad++;
        $display("FAIL augment_final cyc=%0d got=%h want=%h", e.cyc, {Tstate, busy, done, phase, iter_cnt}, e.v);
      end
      align();
    end
    for (int c = 0; c <= 6; c++) begin
      exp_t e;
      set_in(c == 0, 254, 0, c == 2 || c == 3, c == 4);
      #1;
      e = sb.pop_front();
      total++; n++;
      if ({Tstate, busy, done, phase, iter_cnt} !== e.v) begin
        bad++;
        $display("FAIL augment_sat cyc=%0d got=%h want=%h", e.cyc, {Tstate, busy, done, phase, iter_cnt}, e.v);
      end
      align();
    end
    $display("augment: %0d cycles checked", n);
  endtask

  task automatic test_abort();
    int n = 0;
    for (int c = 0; c <= 16; c++) begin
      int cnt = (c >= 1 && c <= 5) ? 5 : (c == 6 || c == 7) ? 4 : (c >= 9 && c <= 13) ? 1 : 0;
      int ph  = (c >= 2 && c <= 7) ? (c - 2) % 4 : (c >= 10 && c <= 13) ? c - 10 : 0;
      push(c, mk(c == 5 || c == 13, (c >= 1 && c <= 7) || (c >= 9 && c <= 13), c == 14, ph, cnt));
    end
    align();
    for (int c = 0; c <= 16; c++) begin
      exp_t e;
      // Augment alongside abort must lose; restart arrives the cycle after.
      set_in(c == 0 || c == 8, (c == 8) ? 1 : 5, 0, c == 7, c == 7);
      #1;
      e = sb.pop_front();
      total++; n++;
      if ({Tstate, busy, done, phase, iter_cnt} !== e.v) begin
        bad++;
        $display("FAIL abort cyc=%0d got=%h want=%h", e.cyc, {Tstate, busy, done, phase, iter_cnt}, e.v);
      end
      align();
    end
    $display("abort: %0d cycles checked", n);
  endtask

  task automatic test_midloop_reset();
    int n = 0;
    for (int c = 0; c <= 16; c++) begin
      int cnt = (c >= 1 && c <= 5) ? 3 : (c == 6) ? 2 : (c >= 10 && c <= 14) ? 1 : 0;
      int ph  = (c >= 2 && c <= 6) ? (c - 2) % 4 : (c >= 11 && c <= 14) ? c - 11 : 0;
      push(c, mk(c == 5 || c == 14, (c >= 1 && c <= 6) || (c >= 10 && c <= 14), c == 15, ph, cnt));
    end
    align();
    for (int c = 0; c <= 16; c++) begin
      exp_t e;
      rst = (c == 6);
      set_in(c == 0 || c == 9, (c == 9) ? 1 : 3, 0, 0, 0);
      #1;
      e = sb.pop_front();
      total++; n++;
      if ({Tstate, busy, done, phase, iter_cnt} !== e.v) begin
        bad++;
        $display("FAIL midloop_reset cyc=%0d got=%h want=%h", e.cyc, {Tstate, busy, done, phase, iter_cnt}, e.v);
      end
      align();
    end
    rst = 1'b0;
    $display("mid-loop reset: %0d cycles checked", n);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_hold();
    test_augment();
    test_abort();
    test_midloop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
